// File: rtl/layer_norm_stream.sv
// Row-streaming layer normalisation (or RMSNorm) with iterative sqrt/reciprocal.
// One row is loaded, reduced, normalised and drained before the next row is accepted.
module layer_norm_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int EMB_DIM    = 8,
    parameter int SEQ_LEN    = 8,
    parameter int EPS        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rms_mode,
    input  logic [DATA_WIDTH*EMB_DIM-1:0] gamma_in,
    input  logic [DATA_WIDTH*EMB_DIM-1:0] beta_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          done
);
    localparam int LOG2_EMB = $clog2(EMB_DIM);
    localparam int COL_W    = LOG2_EMB;
    localparam int ROW_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int SUM_W    = DATA_WIDTH + LOG2_EMB;
    localparam int DIFF_W   = DATA_WIDTH + 1;
    localparam int SQ_W     = 2 * DIFF_W;
    localparam int ACC_W    = SQ_W + LOG2_EMB;
    localparam int VAR_W    = 2 * DATA_WIDTH;
    localparam int REM_W    = DATA_WIDTH + 3;
    localparam int INV_W    = 2 * FRAC_BITS + 1;
    localparam int NORM_P_W = DIFF_W + INV_W + 1;
    localparam int NORM_W   = NORM_P_W - FRAC_BITS;
    localparam int G_P_W    = NORM_W + DATA_WIDTH;
    localparam int G_W      = G_P_W - FRAC_BITS;
    localparam int Y_W      = G_W + 1;
    localparam int CNT_W    = $clog2((INV_W > DATA_WIDTH) ? INV_W : DATA_WIDTH);

    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [Y_W-1:0] Y_MIN = ~Y_MAX;

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_VAR   = 3'd1;
    localparam logic [2:0] S_SQRT  = 3'd2;
    localparam logic [2:0] S_RECIP = 3'd3;
    localparam logic [2:0] S_SCALE = 3'd4;
    localparam logic [2:0] S_NORM  = 3'd5;

    logic [2:0]                    state;
    logic [COL_W-1:0]              col;
    logic [ROW_W-1:0]              row;
    logic [DATA_WIDTH-1:0]         row_buf [EMB_DIM];
    logic [DATA_WIDTH*EMB_DIM-1:0] gamma_r;
    logic [DATA_WIDTH*EMB_DIM-1:0] beta_r;
    logic                          rms_r;
    logic signed [SUM_W-1:0]       sum;
    logic signed [DATA_WIDTH-1:0]  mean;
    logic [ACC_W-1:0]              acc;
    logic [VAR_W-1:0]              rad;
    logic [DATA_WIDTH:0]           sq_rem;
    logic [DATA_WIDTH-1:0]         root;
    logic [DATA_WIDTH-1:0]         div_rem;
    logic [INV_W-1:0]              dividend;
    logic [INV_W-1:0]              quo;
    logic [CNT_W-1:0]              cnt;
    logic [DATA_WIDTH-1:0]         out_data_r;
    logic                          out_last_r;
    logic                          done_r;

    logic signed [SUM_W-1:0]      sum_next;
    logic signed [DIFF_W-1:0]     diff_var;
    logic signed [SQ_W-1:0]       sq;
    logic [ACC_W-1:0]             acc_next;
    logic [ACC_W-1:0]             var_full;
    logic [VAR_W-1:0]             var_sat;
    logic [VAR_W:0]               var_eps_w;
    logic [VAR_W-1:0]             var_eps;
    logic [REM_W-1:0]             rem_sh;
    logic [REM_W-1:0]             trial;
    logic [REM_W-1:0]             rem_sub;
    logic                         rem_ge;
    logic [DATA_WIDTH:0]          r_sh;
    logic [DATA_WIDTH:0]          r_sub;
    logic                         r_ge;
    logic [COL_W-1:0]             y_idx;
    logic signed [DIFF_W-1:0]     diff_y;
    logic signed [NORM_P_W-1:0]   norm_p;
    logic signed [NORM_W-1:0]     norm;
    logic signed [DATA_WIDTH-1:0] gam;
    logic signed [DATA_WIDTH-1:0] bet;
    logic signed [G_P_W-1:0]      g_p;
    logic signed [G_W-1:0]        g;
    logic signed [Y_W-1:0]        y_full;
    logic signed [Y_W-1:0]        y_sat;

    always_comb begin
        sum_next  = sum + SUM_W'($signed(in_data));
        diff_var  = DIFF_W'($signed(row_buf[col])) - DIFF_W'(mean);
        sq        = SQ_W'(diff_var) * SQ_W'(diff_var);
        acc_next  = acc + ACC_W'($unsigned(sq));
        var_full  = acc_next >> LOG2_EMB;
        var_sat   = (|var_full[ACC_W-1:VAR_W]) ? '1 : var_full[VAR_W-1:0];
        var_eps_w = {1'b0, var_sat} + (VAR_W+1)'(EPS);
        var_eps   = var_eps_w[VAR_W] ? '1 : var_eps_w[VAR_W-1:0];

        // Square root: two radicand bits in, one root bit out per cycle.
        rem_sh  = {sq_rem, rad[VAR_W-1 -: 2]};
        trial   = {1'b0, root, 2'b01};
        rem_ge  = (rem_sh >= trial);
        rem_sub = rem_sh - trial;

        r_sh  = {div_rem, dividend[INV_W-1]};
        r_ge  = (r_sh >= {1'b0, root});
        r_sub = r_sh - {1'b0, root};

        // Output register is loaded one column ahead while draining.
        y_idx  = (state == S_NORM) ? col + COL_W'(1) : col;
        diff_y = DIFF_W'($signed(row_buf[y_idx])) - DIFF_W'(mean);
        norm_p = NORM_P_W'(diff_y) * $signed(NORM_P_W'(quo));
        norm   = NORM_W'(norm_p >>> FRAC_BITS);
        gam    = $signed(gamma_r[y_idx*DATA_WIDTH +: DATA_WIDTH]);
        bet    = rms_r ? '0 : $signed(beta_r[y_idx*DATA_WIDTH +: DATA_WIDTH]);
        g_p    = G_P_W'(norm) * G_P_W'(gam);
        g      = G_W'(g_p >>> FRAC_BITS);
        y_full = Y_W'(g) + Y_W'(bet);
        if (y_full > Y_MAX)
            y_sat = Y_MAX;
        else if (y_full < Y_MIN)
            y_sat = Y_MIN;
        else
            y_sat = y_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            col        <= '0;
            row        <= '0;
            sum        <= '0;
            mean       <= '0;
            acc        <= '0;
            rms_r      <= 1'b0;
            rad        <= '0;
            sq_rem     <= '0;
            root       <= '0;
            div_rem    <= '0;
            dividend   <= '0;
            quo        <= '0;
            cnt        <= '0;
            out_data_r <= '0;
            out_last_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        row_buf[col] <= in_data;
                        if (col == '0) begin
                            gamma_r <= gamma_in;
                            beta_r  <= beta_in;
                            rms_r   <= rms_mode;
                        end
                        if (col == COL_W'(EMB_DIM-1)) begin
                            mean  <= rms_r ? '0 : DATA_WIDTH'(sum_next >>> LOG2_EMB);
                            sum   <= '0;
                            acc   <= '0;
                            col   <= '0;
                            state <= S_VAR;
                        end else begin
                            sum <= sum_next;
                            col <= col + COL_W'(1);
                        end
                    end
                end
                S_VAR: begin
                    acc <= acc_next;
                    if (col == COL_W'(EMB_DIM-1)) begin
                        rad    <= var_eps;
                        sq_rem <= '0;
                        root   <= '0;
                        cnt    <= '0;
                        col    <= '0;
                        state  <= S_SQRT;
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                S_SQRT: begin
                    rad    <= rad << 2;
                    sq_rem <= rem_ge ? rem_sub[DATA_WIDTH:0] : rem_sh[DATA_WIDTH:0];
                    root   <= {root[DATA_WIDTH-2:0], rem_ge};
                    if (cnt == CNT_W'(DATA_WIDTH-1)) begin
                        cnt      <= '0;
                        div_rem  <= '0;
                        quo      <= '0;
                        dividend <= {1'b1, {(INV_W-1){1'b0}}};
                        state    <= S_RECIP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RECIP: begin
                    dividend <= dividend << 1;
                    div_rem  <= r_ge ? r_sub[DATA_WIDTH-1:0] : r_sh[DATA_WIDTH-1:0];
                    quo      <= {quo[INV_W-2:0], r_ge};
                    if (cnt == CNT_W'(INV_W-1)) begin
                        cnt   <= '0;
                        col   <= '0;
                        state <= S_SCALE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SCALE: begin
                    out_data_r <= y_sat[DATA_WIDTH-1:0];
                    out_last_r <= (y_idx == COL_W'(EMB_DIM-1));
                    state      <= S_NORM;
                end
                S_NORM: begin
                    if (out_ready) begin
                        if (col == COL_W'(EMB_DIM-1)) begin
                            out_data_r <= '0;
                            out_last_r <= 1'b0;
                            col        <= '0;
                            state      <= S_LOAD;
                            if (row == ROW_W'(SEQ_LEN-1)) begin
                                row    <= '0;
                                done_r <= 1'b1;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            out_data_r <= y_sat[DATA_WIDTH-1:0];
                            out_last_r <= (y_idx == COL_W'(EMB_DIM-1));
                            col        <= col + COL_W'(1);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_NORM);
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign done      = done_r;
endmodule
